// File: rtl/mul_shift_add.sv
// mul_shift_add: sequential unsigned shift-and-add multiplier.
// Each cycle it makes one conditional add, using a W-bit adder built from
// chained 4-bit carry look-ahead blocks, and then shifts right by one bit.
// A W x W multiply completes in W cycles after the operands are captured.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset
//   op_start      start request, acted on only in IDLE
//   op_clear      synchronous abort/clear, acted on in every state
//   multiplicand  operand A (W bits), captured at start
//   multiplier    operand B (W bits), captured at start
//   op_done       high while the product is valid (DONE)
//   result        product register {acc_hi, acc_lo} (2W bits)
module mul_shift_add #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           op_start,
  input  logic           op_clear,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic           op_done,
  output logic [2*W-1:0] result
);

  localparam int unsigned NB = W / 4;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    mcand_q;
  logic [W-1:0]    acc_hi_q;
  logic [W-1:0]    acc_lo_q;
  logic [CW-1:0]   cnt_q;

  // Adder acc_hi + mcand with carry-in 0, made of chained 4-bit CLA blocks.
  logic [NB:0]     carry;
  logic [W-1:0]    sum;
  logic            cout;

  assign carry[0] = 1'b0;

  for (genvar b = 0; b < NB; b++) begin : g_cla
    logic [3:0] ga;
    logic [3:0] pa;
    logic [3:0] cb;

    assign ga = acc_hi_q[4*b +: 4] & mcand_q[4*b +: 4];
    assign pa = acc_hi_q[4*b +: 4] ^ mcand_q[4*b +: 4];

    // Carries for the block, each formed directly from generate/propagate terms.
    assign cb[0] = carry[b];
    assign cb[1] = ga[0] | (pa[0] & cb[0]);
    assign cb[2] = ga[1] | (pa[1] & ga[0]) | (pa[1] & pa[0] & cb[0]);
    assign cb[3] = ga[2] | (pa[2] & ga[1]) | (pa[2] & pa[1] & ga[0])
                 | (pa[2] & pa[1] & pa[0] & cb[0]);
    assign carry[b+1] = ga[3] | (pa[3] & ga[2]) | (pa[3] & pa[2] & ga[1])
                      | (pa[3] & pa[2] & pa[1] & ga[0])
                      | (pa[3] & pa[2] & pa[1] & pa[0] & cb[0]);

    assign sum[4*b +: 4] = pa ^ cb;
  end

  assign cout = carry[NB];

  // Control and datapath registers; reset and clear take priority over all states.
  always_ff @(posedge clk) begin
    if (!reset_n || op_clear) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_start) begin
            mcand_q  <= multiplicand;
            acc_hi_q <= '0;
            acc_lo_q <= multiplier;
            cnt_q    <= '0;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // The adder carry-out becomes the new top bit of the accumulator.
          if (acc_lo_q[0]) begin
            acc_hi_q <= {cout, sum[W-1:1]};
            acc_lo_q <= {sum[0], acc_lo_q[W-1:1]};
          end else begin
            acc_hi_q <= {1'b0, acc_hi_q[W-1:1]};
            acc_lo_q <= {acc_hi_q[0], acc_lo_q[W-1:1]};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign op_done = (state_q == S_DONE);
  assign result  = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add (W=32): table-driven vectors,
// hand-written corner sequences and a random sweep, with a scoreboard queue.
module tb_mul_shift_add;

  localparam int unsigned W = 32;

  logic           clk;
  logic           reset_n;
  logic           op_start;
  logic           op_clear;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           op_done;
  logic [2*W-1:0] result;

  mul_shift_add #(.W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_done      (op_done),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t           vecs [7];
  logic [2*W-1:0] exp_q [$];
  int             n_checks = 0;
  int             n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
  endtask

  // Capture edge with operands; optionally push the expected product.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push);
    multiplicand = a;
    multiplier   = b;
    op_start     = 1'b1;
    if (push) exp_q.push_back(64'(a) * 64'(b));
    tick();
    op_start     = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  // Wait (bounded) for op_done; 'already' = ticks since the capture edge.
  task automatic wait_done(input string name, input int already);
    int n;
    logic [2*W-1:0] e;
    n = already;
    while (n < int'(W) + 4 && !op_done) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(W));
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      if (op_done) check({name, "_result"}, result, e);
      else check({name, "_timeout"}, 64'(op_done), 64'(1));
    end
  endtask

  task automatic clear_op(input string name);
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    check({name, "_clr_done"}, 64'(op_done), 64'(0));
    check({name, "_clr_result"}, result, 64'(0));
  endtask

  initial begin
    vecs[0] = '{a: 32'd24,         b: 32'd5,          exp: 64'h0000000000000078};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   exp: 64'hFFFFFFFE00000001};
    vecs[2] = '{a: 32'h12345678,   b: 32'h0,          exp: 64'h0};
    vecs[3] = '{a: 32'h0,          b: 32'hDEADBEEF,   exp: 64'h0};
    vecs[4] = '{a: 32'd3,          b: 32'd4,          exp: 64'd12};
    vecs[5] = '{a: 32'h80000000,   b: 32'h2,          exp: 64'h0000000100000000};
    vecs[6] = '{a: 32'hFFFFFFFF,   b: 32'h1,          exp: 64'h00000000FFFFFFFF};

    reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0;
    multiplicand = '0; multiplier = '0;
    tick(); tick();
    check("reset_done", 64'(op_done), 64'(0));
    check("reset_result", result, 64'(0));
    reset_n = 1'b1;
    tick();

    // Table vectors; expected products come from the table itself.
    for (int i = 0; i < 7; i++) begin
      multiplicand = vecs[i].a;
      multiplier   = vecs[i].b;
      op_start     = 1'b1;
      tick();
      op_start     = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      exp_q.push_back(vecs[i].exp);
      check($sformatf("vec%0d_busy", i), 64'(op_done), 64'(0));
      wait_done($sformatf("vec%0d", i), 0);
      clear_op($sformatf("vec%0d", i));
    end

    // op_start during EXEC and in DONE is ignored.
    start_op(32'd7, 32'd9, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    multiplicand = 32'd1; multiplier = 32'd1; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    wait_done("restart_exec", 11);
    multiplicand = 32'd2; multiplier = 32'd2; op_start = 1'b1;
    tick(); tick();
    op_start = 1'b0;
    check("restart_done_flag", 64'(op_done), 64'(1));
    check("restart_done_result", result, 64'd63);
    clear_op("restart");

    // op_clear mid-EXEC aborts; block stays idle afterwards.
    start_op(32'd100, 32'd100, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    clear_op("abort");
    for (int i = 0; i < int'(W) + 2; i++) tick();
    check("abort_idle_done", 64'(op_done), 64'(0));
    check("abort_idle_result", result, 64'(0));
    start_op(32'd3, 32'd4, 1'b1);
    wait_done("after_abort", 0);
    clear_op("after_abort");

    // op_start and op_clear on the same edge in IDLE: clear wins.
    multiplicand = 32'd5; multiplier = 32'd6;
    op_start = 1'b1; op_clear = 1'b1;
    tick();
    op_start = 1'b0; op_clear = 1'b0;
    for (int i = 0; i < int'(W) + 2; i++) tick();
    check("start_clear_done", 64'(op_done), 64'(0));
    check("start_clear_result", result, 64'(0));

    // Reset pulse mid-EXEC.
    start_op(32'hABCD, 32'h1234, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_done", 64'(op_done), 64'(0));
    check("midrst_result", result, 64'(0));
    for (int i = 0; i < int'(W) + 2; i++) tick();
    check("midrst_idle_done", 64'(op_done), 64'(0));

    // Random sweep against the A*B reference.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 10 == 0) b = b & 32'h0000FFFF;
      if (i % 10 == 1) a = 32'hFFFFFFFF;
      start_op(a, b, 1'b1);
      wait_done($sformatf("rand%0d", i), 0);
      op_clear = 1'b1;
      tick();
      op_clear = 1'b0;
    end

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
